// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - instruction-cycle sequencer (FETCH/DECODE/EXECUTE/WRITE_BACK) with halt/resume and perf counters; optional SEQ_SINGLE_STEP_EN adds step_mode
module cpu_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             mem_ready,
    input  logic             exec_busy,
    input  logic             is_branch,
    input  logic             halt_req,
    input  logic             run,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic             step_mode,
`endif
    output logic [1:0]       state,
    output logic             fetch_req,
    output logic             pc_enable,
    output logic             reg_write_enable,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [CNT_W-1:0] cycles
);

    // Phase codes match the core-wide FETCH/DECODE/EXECUTE/WRITE_BACK encoding.
    typedef enum logic [1:0] {
        FETCH      = 2'd0,
        DECODE     = 2'd1,
        EXECUTE    = 2'd2,
        WRITE_BACK = 2'd3
    } phase_e;

    phase_e             state_q, state_d;
    logic               halted_q, halted_d;
    logic               resume_skip_q, resume_skip_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   cycles_q, cycles_d;
    logic               resume_to_fetch;

    // A halt taken at a single-step boundary parks in FETCH and resumes there;
    // a halt opcode parks in DECODE and resumes by retiring the halt instruction.
`ifdef SEQ_SINGLE_STEP_EN
    assign resume_to_fetch = (state_q == FETCH);
`else
    assign resume_to_fetch = 1'b0;
`endif

    // Next-state logic for phase, halt flag, resume-skip flag and counters.
    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        resume_skip_d = resume_skip_q;
        retired_d     = retired_q;
        cycles_d      = cycles_q;

        if (halted_q) begin
            if (run) begin
                halted_d = 1'b0;
                if (!resume_to_fetch) begin
                    state_d       = WRITE_BACK;
                    resume_skip_d = 1'b1;
                end
            end
        end else begin
            cycles_d = cycles_q + CNT_W'(1);
            case (state_q)
                FETCH: begin
                    if (mem_ready) begin
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    if (halt_req) begin
                        halted_d = 1'b1;
                    end else begin
                        state_d = EXECUTE;
                    end
                end
                EXECUTE: begin
                    if (!exec_busy) begin
                        state_d = WRITE_BACK;
                    end
                end
                WRITE_BACK: begin
                    state_d       = FETCH;
                    resume_skip_d = 1'b0;
                    retired_d     = retired_q + CNT_W'(1);
`ifdef SEQ_SINGLE_STEP_EN
                    if (step_mode) begin
                        halted_d = 1'b1;
                    end
`endif
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State and counter registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= FETCH;
            halted_q      <= 1'b0;
            resume_skip_q <= 1'b0;
            retired_q     <= '0;
            cycles_q      <= '0;
        end else begin
            state_q       <= state_d;
            halted_q      <= halted_d;
            resume_skip_q <= resume_skip_d;
            retired_q     <= retired_d;
            cycles_q      <= cycles_d;
        end
    end

    // Strobes decode the registered phase; forced low while reset is asserted.
    always_comb begin
        fetch_req        = !reset && !halted_q && (state_q == FETCH);
        pc_enable        = !reset && !halted_q && (state_q == WRITE_BACK);
        reg_write_enable = pc_enable && !is_branch && !resume_skip_q;
    end

    assign state   = state_q;
    assign halted  = halted_q;
    assign retired = retired_q;
    assign cycles  = cycles_q;

endmodule
